// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_pkg
// Description : Mode codes, bounce direction type and initial-pattern helper
//               shared by the LED sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package led_seq_pkg;

  localparam logic [1:0] MODE_BLINK  = 2'b00;
  localparam logic [1:0] MODE_CHASE  = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_COUNT  = 2'b11;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Bit idx of the pattern a mode starts from; evaluated per bit so any
  // LED count works without a fixed maximum width.
  function automatic logic init_bit(input logic [1:0] mode, input int unsigned idx);
    logic b;
    case (mode)
      MODE_BLINK:  b = idx[0];
      MODE_CHASE:  b = (idx == 0);
      MODE_BOUNCE: b = (idx == 0);
      default:     b = 1'b0;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_seq_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_prescaler
// Description : Divides CLK into a one-cycle advance strobe every N enabled
//               cycles; clr restarts the period.
// Revision    : 1.0 - initial release
// ============================================================================
module led_seq_prescaler
  import led_seq_pkg::*;
#(
  parameter int N = 6_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic clr,
  output logic adv
);

  localparam int              CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign adv = EN && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (adv) begin
      cnt_d = '0;
    end else if (EN) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_sequencer
// Description : Multi-channel LED pattern generator (blink/chase/bounce/count)
//               advancing once per prescaler tick. Define LED_SEQ_PWM_DIM_EN
//               to add the DIM port and global PWM brightness gating.
// Revision    : 1.0 - initial release
// ============================================================================
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int N        = 6_000_000,
  parameter int NUM_LEDS = 8
`ifdef LED_SEQ_PWM_DIM_EN
  ,
  parameter int PWM_BITS = 4
`endif
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic [1:0]          MODE,
`ifdef LED_SEQ_PWM_DIM_EN
  input  logic [PWM_BITS-1:0] DIM,
`endif
  output logic [NUM_LEDS-1:0] LED,
  output logic                TICK
);

  logic                mode_q,   mode_unused_n;
  logic [1:0]          mode_r_q;
  logic [1:0]          mode_r_d;
  logic [NUM_LEDS-1:0] pattern_q;
  logic [NUM_LEDS-1:0] pattern_d;
  dir_e                dir_q;
  dir_e                dir_d;
  logic                tick_q;
  logic                tick_d;
  logic [NUM_LEDS-1:0] init_pat;
  logic [NUM_LEDS-1:0] shl;
  logic [NUM_LEDS-1:0] shr;
  logic                mode_chg;
  logic                adv;

  assign mode_q        = 1'b0;
  assign mode_unused_n = mode_q;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_init
    assign init_pat[i] = init_bit(MODE, i);
  end

  assign mode_chg = (MODE != mode_r_q);
  assign shl      = pattern_q << 1;
  assign shr      = pattern_q >> 1;

  led_seq_prescaler #(
    .N (N)
  ) u_prescaler (
    .CLK (CLK),
    .RST (RST),
    .EN  (EN),
    .clr (mode_chg),
    .adv (adv)
  );

  // A mode change outranks a coincident advance: the new mode starts fresh.
  always_comb begin
    mode_r_d  = mode_r_q;
    pattern_d = pattern_q;
    dir_d     = dir_q;
    tick_d    = 1'b0;
    if (mode_chg) begin
      mode_r_d  = MODE;
      pattern_d = init_pat;
      dir_d     = DIR_UP;
    end else if (adv) begin
      tick_d = 1'b1;
      case (mode_r_q)
        MODE_BLINK: pattern_d = ~pattern_q;
        MODE_CHASE: pattern_d = shl | (pattern_q >> (NUM_LEDS - 1));
        MODE_BOUNCE: begin
          if (NUM_LEDS > 1) begin
            if (dir_q == DIR_UP) begin
              pattern_d = shl;
              dir_d     = shl[NUM_LEDS-1] ? DIR_DOWN : DIR_UP;
            end else begin
              pattern_d = shr;
              dir_d     = shr[0] ? DIR_UP : DIR_DOWN;
            end
          end
        end
        default: pattern_d = pattern_q + NUM_LEDS'(1);
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_r_q  <= MODE;
      pattern_q <= init_pat;
      dir_q     <= DIR_UP;
      tick_q    <= 1'b0;
    end else begin
      mode_r_q  <= mode_r_d;
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      tick_q    <= tick_d;
    end
  end

  assign TICK = tick_q;

`ifdef LED_SEQ_PWM_DIM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] pwm_cnt_d;
  logic                lit;

  assign pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
  // Full-scale DIM means fully on rather than on for all-but-one slot.
  assign lit       = (pwm_cnt_q < DIM) || (DIM == {PWM_BITS{1'b1}});

  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign LED = pattern_q & {NUM_LEDS{lit}};
`else
  assign LED = pattern_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_sequencer
// Description : Randomised scoreboard bench for led_sequencer (N=3, 4 LEDs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_sequencer;

  localparam int N = 3;
  localparam int L = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         EN;
  logic [1:0]   MODE;
  logic [L-1:0] LED;
  logic         TICK;
`ifdef LED_SEQ_PWM_DIM_EN
  logic [3:0]   DIM = 4'd15;
`endif

  always #5 CLK = ~CLK;

  led_sequencer #(
    .N        (N),
    .NUM_LEDS (L)
`ifdef LED_SEQ_PWM_DIM_EN
    ,
    .PWM_BITS (4)
`endif
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .MODE (MODE),
`ifdef LED_SEQ_PWM_DIM_EN
    .DIM  (DIM),
`endif
    .LED  (LED),
    .TICK (TICK)
  );

  typedef struct packed {
    logic [L-1:0] led;
    logic         tick;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         passed = 0;
  bit         done   = 1'b0;

  logic [1:0] m_mode = 2'b00;
  int         m_k    = 0;
  int         m_cnt  = 0;
  int         m_pwm  = 0;

  // Pattern after k advances in a mode, from the closed-form sequences.
  function automatic logic [L-1:0] pattern_of(input logic [1:0] mode, input int k);
    logic [L-1:0] b0;
    int           p;
    int           pos;
    for (int i = 0; i < L; i++) b0[i] = (i % 2 == 1);
    case (mode)
      2'b00:   return (k % 2 == 1) ? ~b0 : b0;
      2'b01:   return L'(1) << (k % L);
      2'b10: begin
        if (L == 1) return L'(1);
        p   = k % (2 * (L - 1));
        pos = (p < L) ? p : 2 * (L - 1) - p;
        return L'(1) << pos;
      end
      default: return L'(k % (1 << L));
    endcase
  endfunction

  task automatic step(input logic rst, input logic en, input logic [1:0] mode);
    logic         tick;
    logic [L-1:0] led;
    RST  = rst;
    EN   = en;
    MODE = mode;
    tick = 1'b0;
    if (rst) begin
      m_mode = mode;
      m_k    = 0;
      m_cnt  = 0;
      m_pwm  = 0;
    end else begin
      m_pwm = (m_pwm + 1) % 16;
      if (mode != m_mode) begin
        m_mode = mode;
        m_k    = 0;
        m_cnt  = 0;
      end else if (en) begin
        if (m_cnt == N - 1) begin
          m_cnt = 0;
          m_k   = m_k + 1;
          tick  = 1'b1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    led = pattern_of(m_mode, m_k);
`ifdef LED_SEQ_PWM_DIM_EN
    if (!((m_pwm < int'(DIM)) || (DIM == 4'd15))) led = '0;
`endif
    exp_q.push_back('{led: led, tick: tick});
  endtask

  // Monitor: every edge yields one expected LED/TICK pair.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (!done) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL scoreboard_empty t=%0t LED=%b TICK=%b no expectation queued", $time, LED, TICK);
        end else begin
          e = exp_q.pop_front();
          if (LED !== e.led || TICK !== e.tick)
            $display("FAIL led_tick t=%0t LED=%b TICK=%b required LED=%b TICK=%b",
                     $time, LED, TICK, e.led, e.tick);
          else
            passed++;
        end
      end
    end
  end

  initial begin
    logic [1:0] mode;
    logic       en;
    logic       rst;
    mode = 2'b00;
    step(1'b1, 1'b1, 2'b00);
    @(negedge CLK) step(1'b1, 1'b1, 2'b00);
    for (int m = 0; m < 4; m++) begin
      for (int c = 0; c < 60; c++) begin
        @(negedge CLK) step(1'b0, 1'b1, 2'(m));
      end
    end
    mode = 2'b11;
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK);
      rst = ($urandom_range(0, 99) < 2);
      en  = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 99) < 3) mode = 2'($urandom_range(0, 3));
`ifdef LED_SEQ_PWM_DIM_EN
      if ($urandom_range(0, 99) < 2) begin
        case ($urandom_range(0, 2))
          0:       DIM = 4'd0;
          1:       DIM = 4'd15;
          default: DIM = 4'($urandom_range(0, 15));
        endcase
      end
`endif
      step(rst, en, mode);
    end
    @(posedge CLK);
    #2;
    done = 1'b1;
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain leftover=%0d required=0", exp_q.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
